// File: rtl/seg_pkg.sv
// ============================================================================
// Module   : seg_pkg
// Brief    : Shared constants, digit-entry type and hex segment patterns for
//            the 7-segment display blocks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_pkg;

  localparam int DIGITS  = 4;
  localparam int ENTRY_W = 5;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef struct packed {
    logic                 dp;
    logic [ENTRY_W-2:0]   hex;
  } digit_t;

  // Active-low {g,f,e,d,c,b,a} for hex values 0..F
  localparam logic [0:15][6:0] SEG_PAT = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

`default_nettype wire

// File: rtl/seg_scan_ctrl_if.sv
// ============================================================================
// Module   : seg_scan_ctrl_if
// Brief    : Host write/commit port of the display scan controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seg_scan_ctrl_if;
  import seg_pkg::*;

  logic        wr_en;
  logic [1:0]  wr_addr;
  digit_t      wr_data;
  logic        commit;
  logic        commit_pending;

  modport master (
    output wr_en, wr_addr, wr_data, commit,
    input  commit_pending
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, commit,
    output commit_pending
  );

endinterface

`default_nettype wire

// File: rtl/seg_hex_decode.sv
// ============================================================================
// Module   : seg_hex_decode
// Brief    : Combinational hex digit + decimal point to active-low segments.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_hex_decode
  import seg_pkg::*;
(
  input  wire logic [3:0] hex,
  input  wire logic       dp,
  output logic      [7:0] segs
);

  assign segs = {~dp, SEG_PAT[hex]};

endmodule

`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
// ============================================================================
// Module   : seg_scan_ctrl
// Brief    : 4-digit multiplexed 7-segment scanner with double-buffered store,
//            blanking gap between digits and frame-synchronous commit.
//            Optional leading-zero blanking when SEG_LZB_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int SCAN_HZ   = 1000,
  parameter int BLANK_CYC = 64
) (
  input  wire logic        clock,
  input  wire logic        reset_n,
  seg_scan_ctrl_if.slave   host,
  output logic             frame_tick,
  output logic [7:0]       segs,
  output logic [3:0]       digs
);

  localparam int DWELL_CYC = CLK_HZ / SCAN_HZ;
  localparam int CNT_W     = $clog2(DWELL_CYC);

  localparam logic [CNT_W-1:0] C_CNT_LAST  = CNT_W'(DWELL_CYC - 1);
  localparam logic [CNT_W-1:0] C_CNT_BLANK = CNT_W'(BLANK_CYC);

  digit_t            r_shadow [DIGITS];
  digit_t            r_active [DIGITS];
  logic [CNT_W-1:0]  r_count;
  logic [1:0]        r_index;
  logic              r_pending;
  logic              r_tick;
  logic [7:0]        r_segs;
  logic [3:0]        r_digs;

  logic              w_boundary;
  logic              w_lz_blank;
  digit_t            w_cur;
  logic [7:0]        w_dec_segs;

  assign w_boundary = (r_count == C_CNT_LAST) && (r_index == 2'd3);
  assign w_cur      = r_active[r_index];

  seg_hex_decode u_dec (
    .hex  (w_cur.hex),
    .dp   (w_cur.dp),
    .segs (w_dec_segs)
  );

`ifdef SEG_LZB_EN
  logic [DIGITS-1:0] w_zero;
  logic [DIGITS-1:0] w_zero_run;

  for (genvar g = 0; g < DIGITS; g++) begin : g_zero
    assign w_zero[g] = (r_active[g] == '0);
  end

  // w_zero_run[k]: entry k and every entry above it are zero
  assign w_zero_run[DIGITS-1] = w_zero[DIGITS-1];
  for (genvar g = 0; g < DIGITS - 1; g++) begin : g_run
    assign w_zero_run[g] = w_zero[g] & w_zero_run[g+1];
  end

  assign w_lz_blank = (r_index != 2'd0) && w_zero_run[r_index];
`else
  assign w_lz_blank = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < DIGITS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
      r_count   <= '0;
      r_index   <= 2'd0;
      r_pending <= 1'b0;
      r_tick    <= 1'b0;
      r_segs    <= SEG_BLANK;
      r_digs    <= 4'hF;
    end else begin
      if (r_count == C_CNT_LAST) begin
        r_count <= '0;
        r_index <= r_index + 2'd1;
      end else begin
        r_count <= r_count + CNT_W'(1);
      end

      // Boundary copy uses the pre-edge shadow, so a same-cycle write waits
      if (host.wr_en) begin
        r_shadow[host.wr_addr] <= host.wr_data;
      end

      if (w_boundary && (r_pending || host.commit)) begin
        r_active  <= r_shadow;
        r_pending <= 1'b0;
      end else if (host.commit) begin
        r_pending <= 1'b1;
      end

      r_tick <= w_boundary;

      if (r_count < C_CNT_BLANK) begin
        r_segs <= SEG_BLANK;
        r_digs <= 4'hF;
      end else begin
        r_digs <= ~(4'b0001 << r_index);
        r_segs <= w_lz_blank ? SEG_BLANK : w_dec_segs;
      end
    end
  end

  assign host.commit_pending = r_pending;
  assign frame_tick          = r_tick;
  assign segs                = r_segs;
  assign digs                = r_digs;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Brief    : Self-checking bench for seg_scan_ctrl against a frame-position
//            reference model (DWELL_CYC=10, BLANK_CYC=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_ctrl;

  localparam int DWELL = 10;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * DWELL;

  logic       clock;
  logic       reset_n;
  logic       frame_tick;
  logic [7:0] segs;
  logic [3:0] digs;

  seg_scan_ctrl_if host_bus ();

  seg_scan_ctrl #(
    .CLK_HZ    (1000),
    .SCAN_HZ   (100),
    .BLANK_CYC (BLANK)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .host       (host_bus),
    .frame_tick (frame_tick),
    .segs       (segs),
    .digs       (digs)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  logic [6:0] pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: position within the frame (0..39) plus the two stores
  int         pos;
  logic [4:0] m_active [4];
  logic [4:0] m_shadow [4];
  bit         m_pend;
  logic [7:0] e_segs;
  logic [3:0] e_digs;
  logic       e_tick;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    pos    = 0;
    m_pend = 0;
    for (int i = 0; i < 4; i++) begin
      m_active[i] = '0;
      m_shadow[i] = '0;
    end
  endtask

  task automatic step(input logic rn, input logic we, input logic [1:0] a,
                      input logic [4:0] d, input logic cm);
    int  idx;
    int  cnt;
    bit  lz;
    @(negedge clock);
    reset_n          = rn;
    host_bus.wr_en   = we;
    host_bus.wr_addr = a;
    host_bus.wr_data = d;
    host_bus.commit  = cm;
    @(posedge clock);
    if (!rn) begin
      model_reset();
      e_segs = 8'hFF;
      e_digs = 4'hF;
      e_tick = 1'b0;
    end else begin
      idx = pos / DWELL;
      cnt = pos % DWELL;
      lz  = 0;
`ifdef SEG_LZB_EN
      if (idx != 0) begin
        lz = 1;
        for (int k = idx; k < 4; k++) if (m_active[k] != 5'd0) lz = 0;
      end
`endif
      if (cnt < BLANK) begin
        e_segs = 8'hFF;
        e_digs = 4'hF;
      end else begin
        e_digs = 4'hF;
        e_digs[idx] = 1'b0;
        e_segs = lz ? 8'hFF : {~m_active[idx][4], pat[m_active[idx][3:0]]};
      end
      e_tick = (pos == FRAME - 1);
      if (pos == FRAME - 1 && (m_pend || cm)) begin
        for (int i = 0; i < 4; i++) m_active[i] = m_shadow[i];
        m_pend = 0;
      end else if (cm) begin
        m_pend = 1;
      end
      if (we) m_shadow[a] = d;
      pos = (pos + 1) % FRAME;
    end
    #1;
    chk("segs", segs, e_segs);
    chk("digs", {4'h0, digs}, {4'h0, e_digs});
    chk("frame_tick", {7'h0, frame_tick}, {7'h0, e_tick});
    chk("commit_pending", {7'h0, host_bus.commit_pending}, {7'h0, m_pend});
    chk("digs_one_low", {7'h0, ($countones(~digs) <= 1)}, 8'h01);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 2'd0, 5'd0, 1'b0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [4:0] d);
    step(1'b1, 1'b1, a, d, 1'b0);
  endtask

  task automatic commit_now();
    step(1'b1, 1'b0, 2'd0, 5'd0, 1'b1);
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < FRAME && pos != target; i++) idle(1);
  endtask

  initial begin
    reset_n          = 1'b0;
    host_bus.wr_en   = 1'b0;
    host_bus.wr_addr = 2'd0;
    host_bus.wr_data = '0;
    host_bus.commit  = 1'b0;
    model_reset();

    // Reset values, then two blank cycles and "0" on digit 0
    step(1'b0, 1'b0, 2'd0, 5'd0, 1'b0);
    chk("reset_segs", segs, 8'hFF);
    chk("reset_digs", {4'h0, digs}, 8'h0F);
    idle(2);
    chk("first_blank_segs", segs, 8'hFF);
    idle(1);
    chk("first_show_segs", segs, 8'hC0);
    chk("first_show_digs", {4'h0, digs}, 8'h0E);
    idle(2 * FRAME);

    // 1,2,3,4 with commit
    wr(2'd0, 5'h01); wr(2'd1, 5'h02); wr(2'd2, 5'h03); wr(2'd3, 5'h04);
    commit_now();
    chk("pending_after_commit", {7'h0, host_bus.commit_pending}, 8'h01);
    idle(2 * FRAME + 5);

    // Shadow-only write, display unchanged, then commit
    wr(2'd2, 5'h1A);
    idle(3 * FRAME);
    commit_now();
    idle(2 * FRAME);

    // Commit and write together in the boundary cycle
    wr(2'd3, 5'h09);
    run_to(FRAME - 1);
    step(1'b1, 1'b1, 2'd0, 5'h07, 1'b1);
    chk("boundary_pending_clear", {7'h0, host_bus.commit_pending}, 8'h00);
    idle(FRAME + 3);
    commit_now();
    idle(2 * FRAME);

    // Leading-zero patterns {0,0,0,5} then {0,1,0,0}
    wr(2'd3, 5'h00); wr(2'd2, 5'h00); wr(2'd1, 5'h00); wr(2'd0, 5'h05);
    commit_now();
    idle(2 * FRAME);
    wr(2'd2, 5'h01); wr(2'd0, 5'h00);
    commit_now();
    idle(2 * FRAME);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 600) != 0, ($urandom % 3) == 0, 2'($urandom),
           5'($urandom), ($urandom % 40) == 0);
    end

    // Reset during digit 2 SHOW with a commit pending
    wr(2'd1, 5'h0C);
    run_to(2 * DWELL);
    commit_now();
    run_to(2 * DWELL + 4);
    chk("pending_before_reset", {7'h0, host_bus.commit_pending}, 8'h01);
    step(1'b0, 1'b0, 2'd0, 5'd0, 1'b0);
    chk("midreset_pending", {7'h0, host_bus.commit_pending}, 8'h00);
    chk("midreset_segs", segs, 8'hFF);
    chk("midreset_digs", {4'h0, digs}, 8'h0F);
    chk("midreset_tick", {7'h0, frame_tick}, 8'h00);
    idle(2 * FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the kit's 4-digit common-anode 7-segment display. It holds a double-buffered 4-entry digit store written by the host logic. It cycles the four digit enables with a programmable dwell time and a blanking gap between digits to prevent ghosting. It drives the active-low segment and digit lines directly and replaces the all-digits-on static drive used so far.

## Interface
- CLK_HZ, 50_000_000, input clock frequency in Hz
- SCAN_HZ, 1000, digit step rate; per-digit dwell DWELL_CYC = CLK_HZ/SCAN_HZ cycles (localparam)
- BLANK_CYC, 64, cycles at start of each dwell with all digits off; must satisfy 1 <= BLANK_CYC < DWELL_CYC
- clock  in  1  single system clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- wr_en  in  1  write strobe to shadow store
- wr_addr  in  2  digit index, 0 = rightmost (digs[0]), 3 = leftmost
- wr_data  in  5  {dp, hex[3:0]}; dp=1 lights the decimal point
- commit  in  1  one-cycle request to copy shadow to active store at next frame boundary
- commit_pending  out  1  commit requested, not yet applied
- frame_tick  out  1  one-cycle pulse at each frame boundary
- segs  out  8  active-low {dp,g,f,e,d,c,b,a}
- digs  out  4  active-low digit enables, at most one low

## Operation
- Shadow store: 4×5 bits; wr_en writes wr_data at wr_addr; last write wins; writes are accepted every cycle, with no back-pressure.
- Active store: 4×5 bits, read only by the scanner; loaded only at frame boundary.
- Scanner: dwell counter 0..DWELL_CYC-1 plus digit index 0..3, wrapping 3→0.
- Phases within a dwell:
  - BLANK (count < BLANK_CYC): digs=4'b1111, segs=8'hFF.
  - SHOW: digs has bit[index] low; segs = decode(active[index]).
- Decode (hex → segs[6:0]): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- segs[7] = ~dp.
- Frame boundary: cycle where count=DWELL_CYC-1 and index=3.
  - frame_tick registered high for the following cycle, which is the first BLANK cycle of digit 0.
- Commit handshake:
  - commit sets commit_pending.
  - At a frame boundary with pending set, or with commit asserted in that same cycle: active ← shadow (as registered before the cycle), and commit_pending clears.
  - A wr_en in the boundary cycle lands in shadow only and waits for the next commit.
  - commit while already pending has no additional effect.
- Store arithmetic is unsigned. Dwell counter width is $clog2(DWELL_CYC).

## Timing
- Reset values, applied on the first rising edge with reset_n low:
  - segs=8'hFF, digs=4'hF, frame_tick=0, commit_pending=0.
  - count=0, index=0.
  - Both stores = 5'b0_0000, so "0000" with no dp is shown after reset.
- Reset mid-frame: scan restarts at digit 0 BLANK; a pending commit is discarded.
- segs/digs are registered, one cycle after counter state.
- digs never has two bits low; BLANK separates every digit change, including the 3→0 wrap.
- Frame period = 4·DWELL_CYC cycles. Commit-to-display latency ≤ 4·DWELL_CYC+1 cycles.

## Configuration
- SEG_LZB_EN defined: leading-zero blanking in SHOW phase.
  - Digit k (k=3..1) is blanked (segs=8'hFF, digs still driven) when its active entry and all entries above it are 5'b0_0000.
  - Digit 0 is never blanked.
- SEG_LZB_EN undefined: every digit shows its decoded entry; no extra logic.

## Structure
- Package seg_pkg:
  - digit count (4), entry width (5), SEG_BLANK=8'hFF;
  - typedef for a 5-bit digit entry;
  - 16-entry segment pattern constant.
- Sub-module seg_hex_decode: combinational hex+dp → segs, shared with other display blocks.
- Scanner, stores and commit logic in seg_scan_ctrl.

## Test plan
All tests use CLK_HZ=1000, SCAN_HZ=100 (DWELL_CYC=10) and BLANK_CYC=2.
- Reset → segs=8'hFF, digs=4'hF. Then 2 cycles blank, then digs=4'b1110, segs=8'hC0 for 8 cycles; frame_tick every 40 cycles.
- Write addr0..3 = 1,2,3,4 then commit → commit_pending high until boundary. Next frame shows 8'hF9, 8'hA4, 8'hB0, 8'h99 on digs 1110, 1101, 1011, 0111.
- Write addr2=5'h1A without commit → display unchanged for 3 frames. Then commit → 8'h08 on digit 2 with dp lit.
- commit and wr_en(addr0=7) in the boundary cycle → prior shadow applied, pending=0. Digit 0 shows 7 only after another commit.
- SEG_LZB_EN, active = {0,0,0,5} (digit 3..0) → digits 3..1 segs=8'hFF, digit 0 segs=8'h92. With {0,1,0,0}, digits 1 and 0 show 8'hC0.
- Assert reset_n low during SHOW of digit 2 with commit pending → next cycle all outputs at reset values, commit_pending=0. The check that digs never has more than one bit low runs throughout.
